// File: rtl/snoop_bus_ctrl_if.sv
// Bus bundle between the snoop bus controller and its N cache controllers.
// The controller side uses the slave modport; the caches use master.
interface snoop_bus_ctrl_if #(
  parameter int N      = 4,
  parameter int ADDR_W = 32
);
  logic [N-1:0]        req_valid;
  logic [2*N-1:0]      req_op;
  logic [N*ADDR_W-1:0] req_addr;
  logic [N-1:0]        req_grant;
  logic [N-1:0]        snp_valid;
  logic [1:0]          snp_op;
  logic [ADDR_W-1:0]   snp_addr;
  logic [N-1:0]        snp_ack;
  logic [N-1:0]        snp_shared;
  logic [N-1:0]        snp_dirty;
  logic [N-1:0]        cpl_valid;
  logic                cpl_shared;
  logic                cpl_dirty;
  logic                cpl_err;
  logic                busy;

  modport master (
    output req_valid, req_op, req_addr, snp_ack, snp_shared, snp_dirty,
    input  req_grant, snp_valid, snp_op, snp_addr,
    input  cpl_valid, cpl_shared, cpl_dirty, cpl_err, busy
  );

  modport slave (
    input  req_valid, req_op, req_addr, snp_ack, snp_shared, snp_dirty,
    output req_grant, snp_valid, snp_op, snp_addr,
    output cpl_valid, cpl_shared, cpl_dirty, cpl_err, busy
  );
endinterface

// File: rtl/snoop_bus_ctrl.sv
// Round-robin snoop bus controller: one coherence transaction in flight.
// Optional macro SNOOP_TIMEOUT_EN bounds the snoop phase to TIMEOUT cycles.
module snoop_bus_ctrl_lane (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic load_val,
  input  logic abort,
  input  logic ack,
  input  logic shared,
  input  logic dirty,
  output logic pend,
  output logic hit,
  output logic shared_hit,
  output logic dirty_hit
);
  assign hit        = pend & ack;
  assign shared_hit = hit & shared;
  assign dirty_hit  = hit & dirty;

  always_ff @(posedge clk) begin
    if (rst || abort)  pend <= 1'b0;
    else if (load)     pend <= load_val;
    else if (hit)      pend <= 1'b0;
  end
endmodule

module snoop_bus_ctrl #(
  parameter int N       = 4,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst,
  snoop_bus_ctrl_if.slave  bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  typedef logic [N-1:0] vec_t;
  typedef enum logic [1:0] {IDLE, GRANT, SNOOP, COMPLETE} state_t;

  state_t            state;
  logic [PW-1:0]     rr_ptr, win, pick;
  vec_t              win_oh, pend, hit, sh_hit, dt_hit;
  vec_t              grant_q, cpl_q;
  logic              cpl_sh_q, cpl_dt_q, cpl_err_q;
  logic              acc_sh, acc_dt;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic              any_req, rsvd, no_snoop, load, abort, done, sh_now, dt_now;

  assign win_oh   = vec_t'(1) << win;
  assign rsvd     = (op_q == 2'b11);
  assign no_snoop = (N == 1) || rsvd;
  assign load     = (state == GRANT) && !no_snoop;
  assign done     = ((pend & ~hit) == '0);
  assign sh_now   = |sh_hit;
  assign dt_now   = |dt_hit;

  // Upward search from rr_ptr, wrapping N-1 -> 0.
  always_comb begin
    int idx;
    any_req = 1'b0;
    pick    = '0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any_req && bus.req_valid[idx]) begin
        any_req = 1'b1;
        pick    = PW'(idx);
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    snoop_bus_ctrl_lane u_lane (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_val   (~win_oh[i]),
      .abort      (abort),
      .ack        (bus.snp_ack[i]),
      .shared     (bus.snp_shared[i]),
      .dirty      (bus.snp_dirty[i]),
      .pend       (pend[i]),
      .hit        (hit[i]),
      .shared_hit (sh_hit[i]),
      .dirty_hit  (dt_hit[i])
    );
  end

`ifdef SNOOP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          expire;
  assign expire = (state == SNOOP) && !done && (tcnt == TW'(TIMEOUT - 1));
  assign abort  = expire;

  always_ff @(posedge clk) begin
    if (rst || state != SNOOP) tcnt <= '0;
    else                       tcnt <= tcnt + 1'b1;
  end
`else
  logic expire;
  assign expire = 1'b0;
  assign abort  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      win       <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      grant_q   <= '0;
      cpl_q     <= '0;
      cpl_sh_q  <= 1'b0;
      cpl_dt_q  <= 1'b0;
      cpl_err_q <= 1'b0;
      acc_sh    <= 1'b0;
      acc_dt    <= 1'b0;
    end else begin
      grant_q   <= '0;
      cpl_q     <= '0;
      cpl_sh_q  <= 1'b0;
      cpl_dt_q  <= 1'b0;
      cpl_err_q <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          state   <= GRANT;
          win     <= pick;
          grant_q <= vec_t'(1) << pick;
          op_q    <= bus.req_op[2*int'(pick) +: 2];
          addr_q  <= bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
          acc_sh  <= 1'b0;
          acc_dt  <= 1'b0;
        end
        GRANT: begin
          if (no_snoop) begin
            state     <= COMPLETE;
            cpl_q     <= win_oh;
            cpl_err_q <= rsvd;
          end else begin
            state <= SNOOP;
          end
        end
        SNOOP: begin
          acc_sh <= acc_sh | sh_now;
          acc_dt <= acc_dt | dt_now;
          // Status includes acks sampled on the exit edge itself.
          if (done || expire) begin
            state     <= COMPLETE;
            cpl_q     <= win_oh;
            cpl_sh_q  <= acc_sh | sh_now;
            cpl_dt_q  <= acc_dt | dt_now;
            cpl_err_q <= !done;
          end
        end
        COMPLETE: begin
          state  <= IDLE;
          rr_ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_grant  = grant_q;
  assign bus.snp_valid  = pend;
  assign bus.snp_op     = op_q;
  assign bus.snp_addr   = addr_q;
  assign bus.cpl_valid  = cpl_q;
  assign bus.cpl_shared = cpl_sh_q;
  assign bus.cpl_dirty  = cpl_dt_q;
  assign bus.cpl_err    = cpl_err_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Scoreboard bench for snoop_bus_ctrl (N=4): grants and completions are
// queued when stimulus is driven and popped by a negedge monitor.
module tb_snoop_bus_ctrl;
`ifdef SNOOP_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  typedef struct packed {
    logic [3:0] v;
    logic       sh, dt, err;
  } cpl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  logic [3:0] gq[$];
  cpl_t       cq[$];
  cpl_t       mon_e;

  snoop_bus_ctrl_if #(.N(4), .ADDR_W(32)) bus ();

  snoop_bus_ctrl #(.N(4), .ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.req_grant != '0) begin
      if (gq.size() == 0) check("grant_unexpected", 64'(bus.req_grant), 64'd0);
      else                check("grant", 64'(bus.req_grant), 64'(gq.pop_front()));
    end
    if (bus.cpl_valid != '0) begin
      if (cq.size() == 0) check("cpl_unexpected", 64'(bus.cpl_valid), 64'd0);
      else begin
        mon_e = cq.pop_front();
        check("cpl_valid",  64'(bus.cpl_valid),  64'(mon_e.v));
        check("cpl_shared", 64'(bus.cpl_shared), 64'(mon_e.sh));
        check("cpl_dirty",  64'(bus.cpl_dirty),  64'(mon_e.dt));
        check("cpl_err",    64'(bus.cpl_err),    64'(mon_e.err));
      end
    end else if ({bus.cpl_shared, bus.cpl_dirty, bus.cpl_err} != 3'b000) begin
      check("cpl_flags_idle", 64'({bus.cpl_shared, bus.cpl_dirty, bus.cpl_err}), 64'd0);
    end
  end

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] addr);
    bus.req_valid[i]        = 1'b1;
    bus.req_op[2*i +: 2]    = op;
    bus.req_addr[i*32 +: 32] = addr;
  endtask

  // Requester model: holds its request until the grant pulse is seen.
  task automatic wait_grant();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.req_grant != '0) seen = 1'b1;
    end
    if (!seen) check("grant_timeout", 64'd0, 64'd1);
    else bus.req_valid = bus.req_valid & ~bus.req_grant;
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge clk);
      if (!bus.busy) idle = 1'b1;
    end
    if (!idle) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_grant"}, 64'(bus.req_grant), 64'd0);
    check({tag, "_snp"},   64'(bus.snp_valid), 64'd0);
    check({tag, "_cpl"},   64'({bus.cpl_valid, bus.cpl_shared, bus.cpl_dirty, bus.cpl_err}), 64'd0);
    check({tag, "_addr"},  64'({bus.snp_addr, bus.snp_op}), 64'd0);
    check({tag, "_busy"},  64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [3:0] exp_snp [7];
    bus.req_valid  = '0;
    bus.req_op     = '0;
    bus.req_addr   = '0;
    bus.snp_ack    = '0;
    bus.snp_shared = '0;
    bus.snp_dirty  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    all_zero("reset");
    rst = 1'b0;

    // Cache 1 BusRd, all ack at once, cache 2 shared: T+1/T+2/T+3 latency
    bus.snp_ack = 4'b1111; bus.snp_shared = 4'b0100;
    gq.push_back(4'b0010); cq.push_back('{4'b0010, 1'b1, 1'b0, 1'b0});
    set_req(1, 2'b00, 32'h100);
    wait_grant();
    check("t1_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("t1_snp_valid", 64'(bus.snp_valid), 64'b1101);
    check("t1_snp_addr",  64'(bus.snp_addr), 64'h100);
    check("t1_snp_op",    64'(bus.snp_op), 64'd0);
    @(negedge clk);
    check("t1_cpl_cycle", 64'(bus.cpl_valid), 64'b0010);
    @(negedge clk);
    check("t1_idle", 64'({bus.busy, bus.cpl_valid}), 64'd0);

    // Round robin from a fresh pointer: 0 then 3, then 0 again after wrap
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    bus.snp_shared = '0;
    gq.push_back(4'b0001); cq.push_back('{4'b0001, 1'b0, 1'b0, 1'b0});
    gq.push_back(4'b1000); cq.push_back('{4'b1000, 1'b0, 1'b0, 1'b0});
    set_req(0, 2'b00, 32'h200);
    set_req(3, 2'b01, 32'h300);
    wait_grant();
    wait_grant();
    check("t2_second_addr", 64'(bus.snp_addr), 64'h300);
    wait_idle();
    gq.push_back(4'b0001); cq.push_back('{4'b0001, 1'b0, 1'b0, 1'b0});
    set_req(0, 2'b00, 32'h204);
    wait_grant();
    wait_idle();

    // Cache 0 BusRdX, staggered acks, cache 3 dirty: cpl at snoop cycle 6
    bus.snp_ack = '0; bus.snp_dirty = 4'b1000;
    exp_snp = '{4'b1110, 4'b1100, 4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b0000};
    gq.push_back(4'b0001); cq.push_back('{4'b0001, 1'b0, 1'b1, 1'b0});
    set_req(0, 2'b01, 32'h240);
    wait_grant();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check($sformatf("t3_snp_c%0d", c), 64'(bus.snp_valid), 64'(exp_snp[c]));
      check($sformatf("t3_cpl_c%0d", c), 64'(bus.cpl_valid), (c == 6) ? 64'b0001 : 64'd0);
      bus.snp_ack = (c == 0) ? 4'b0010 : (c == 3) ? 4'b0100 : (c == 5) ? 4'b1000 : 4'b0000;
    end
    bus.snp_dirty = '0;
    wait_idle();

    // Reserved op: no snoop phase, error completion
    bus.snp_ack = 4'b1111;
    gq.push_back(4'b0100); cq.push_back('{4'b0100, 1'b0, 1'b0, 1'b1});
    set_req(2, 2'b11, 32'h3C0);
    wait_grant();
    @(negedge clk);
    check("t4_no_snoop", 64'(bus.snp_valid), 64'd0);
    check("t4_cpl", 64'(bus.cpl_valid), 64'b0100);
    wait_idle();

    // Reset mid-SNOOP: everything zero, no completion, pointer back to 0
    bus.snp_ack = '0;
    gq.push_back(4'b0001);
    set_req(0, 2'b00, 32'h500);
    wait_grant();
    @(negedge clk);
    check("t5_pending", 64'(bus.snp_valid), 64'b1110);
    rst = 1'b1;
    @(negedge clk);
    all_zero("t5_abort");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    bus.snp_ack = 4'b1111;
    gq.push_back(4'b0001); cq.push_back('{4'b0001, 1'b0, 1'b0, 1'b0});
    gq.push_back(4'b1000); cq.push_back('{4'b1000, 1'b0, 1'b0, 1'b0});
    set_req(0, 2'b00, 32'h600);
    set_req(3, 2'b00, 32'h700);
    wait_grant();
    wait_grant();
    wait_idle();

    // Cache 3 never acks
    bus.snp_ack = 4'b0110; bus.snp_shared = 4'b0010;
`ifdef SNOOP_TIMEOUT_EN
    gq.push_back(4'b0001); cq.push_back('{4'b0001, 1'b1, 1'b0, 1'b1});
    set_req(0, 2'b00, 32'h800);
    wait_grant();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check($sformatf("t6_cpl_c%0d", c), 64'(bus.cpl_valid), (c == 8) ? 64'b0001 : 64'd0);
    end
    check("t6_snp_dropped", 64'(bus.snp_valid), 64'd0);
`else
    gq.push_back(4'b0001);
    set_req(0, 2'b00, 32'h800);
    wait_grant();
    repeat (70) @(negedge clk);
    check("t6_still_pending", 64'({bus.busy, bus.snp_valid}), 64'b11000);
    cq.push_back('{4'b0001, 1'b1, 1'b1, 1'b0});
    bus.snp_ack = 4'b1000; bus.snp_dirty = 4'b1000;
    @(negedge clk);
    check("t6_cpl", 64'(bus.cpl_valid), 64'b0001);
`endif
    wait_idle();

    check("grant_queue_empty", 64'(gq.size()), 64'd0);
    check("cpl_queue_empty",   64'(cq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
